// File: rtl/mbist_pkg.sv
// Shared definitions for the March C- memory BIST controller: element table
// and controller state type.
package mbist_pkg;

    localparam int NUM_ELEM = 6;

    // state | meaning
    // IDLE  | waiting for start, memory port parked on reads
    // SETUP | one cycle loading element write data and first address
    // RUN   | one memory operation per cycle for the current element
    // DRAIN | two cycles letting the last reads reach the comparator
    // DONE  | one-cycle done pulse, busy already low
    typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_t;

    // One March element: direction, number of ops per address, whether each
    // op is a write, the background expected on reads and the write value.
    typedef struct packed {
        logic descending;
        logic two_ops;
        logic op0_write;
        logic op1_write;
        logic rd_one;
        logic wr_one;
    } elem_t;

    // March C-: E0 w0, E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1),
    // E4 down(r1,w0), E5 r0. E5 write value is unused and parked at D0.
    function automatic elem_t elem_info(input logic [2:0] e);
        elem_t r;
        case (e)
            3'd0:    r = '{descending: 1'b0, two_ops: 1'b0, op0_write: 1'b1, op1_write: 1'b0, rd_one: 1'b0, wr_one: 1'b0};
            3'd1:    r = '{descending: 1'b0, two_ops: 1'b1, op0_write: 1'b0, op1_write: 1'b1, rd_one: 1'b0, wr_one: 1'b1};
            3'd2:    r = '{descending: 1'b0, two_ops: 1'b1, op0_write: 1'b0, op1_write: 1'b1, rd_one: 1'b1, wr_one: 1'b0};
            3'd3:    r = '{descending: 1'b1, two_ops: 1'b1, op0_write: 1'b0, op1_write: 1'b1, rd_one: 1'b0, wr_one: 1'b1};
            3'd4:    r = '{descending: 1'b1, two_ops: 1'b1, op0_write: 1'b0, op1_write: 1'b1, rd_one: 1'b1, wr_one: 1'b0};
            default: r = '{descending: 1'b0, two_ops: 1'b0, op0_write: 1'b0, op1_write: 1'b0, rd_one: 1'b0, wr_one: 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mbist_cmp_pipe.sv
// Two-stage delay line matching the memory read latency, plus sticky
// first-mismatch capture.
module mbist_cmp_pipe
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  fail,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH-1:0] fail_addr
);

    logic                  v1, v2;
    logic [DATA_WIDTH-1:0] e1, e2;
    logic [ADDR_WIDTH-1:0] a1, a2;

    // Shift read expectations along so they meet rdata two cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; e1 <= '0; a1 <= '0;
            v2 <= 1'b0; e2 <= '0; a2 <= '0;
        end else if (clear) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= push; e1 <= exp_data; a1 <= addr;
            v2 <= v1;   e2 <= e1;       a2 <= a1;
        end
    end

    // Keep only the first mismatch; a new test clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (clear) begin
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else if (v2 && (rdata != e2) && !fail) begin
            fail      <= 1'b1;
            fail_addr <= a2;
            fail_data <= rdata;
        end
    end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST master for a single-port test memory with registered write
// data and two-cycle read latency.
module mbist_march_ctrl
    import mbist_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CAPACITY   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY - 1);
    localparam logic [2:0]            LAST_ELEM = 3'(NUM_ELEM - 1);

    state_t                state_q, state_d;
    logic [2:0]            elem_q, elem_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  op_q, op_d;
    logic                  drain_q, drain_d;

    elem_t                 info, next_info;
    logic                  op_is_write, last_op;
    logic [ADDR_WIDTH-1:0] end_addr, next_first;
    logic                  push, clear;

    assign info        = elem_info(elem_q);
    assign next_info   = elem_info(elem_q + 3'd1);
    assign op_is_write = op_q ? info.op1_write : info.op0_write;
    assign last_op     = info.two_ops ? op_q : 1'b1;
    assign end_addr    = info.descending ? '0 : LAST_ADDR;
    assign next_first  = next_info.descending ? LAST_ADDR : '0;

    // Write data is constant per element so the memory's registered wdata
    // is already correct on the element's first RUN cycle.
    assign mem_address = addr_q;
    assign mem_wdata   = {DATA_WIDTH{info.wr_one}};

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            elem_q  <= '0;
            addr_q  <= '0;
            op_q    <= 1'b0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            drain_q <= drain_d;
        end
    end

    // Next-state sequencing and memory command decode.
    always_comb begin
        state_d        = state_q;
        elem_d         = elem_q;
        addr_d         = addr_q;
        op_d           = op_q;
        drain_d        = drain_q;
        busy           = 1'b0;
        done           = 1'b0;
        mem_write_read = 1'b0;
        push           = 1'b0;
        clear          = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    elem_d  = '0;
                    addr_d  = '0;
                    op_d    = 1'b0;
                    clear   = 1'b1;
                end
            end
            SETUP: begin
                busy    = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                busy           = 1'b1;
                mem_write_read = op_is_write;
                push           = !op_is_write;
                if (!last_op) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (addr_q == end_addr) begin
                        if (elem_q == LAST_ELEM) begin
                            state_d = DRAIN;
                            drain_d = 1'b1;
                        end else begin
                            state_d = SETUP;
                            elem_d  = elem_q + 3'd1;
                            addr_d  = next_first;
                        end
                    end else if (info.descending) begin
                        addr_d = addr_q - 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == 1'b0) state_d = DONE;
                else                 drain_d = drain_q - 1'b1;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    mbist_cmp_pipe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .push     (push),
        .exp_data ({DATA_WIDTH{info.rd_one}}),
        .addr     (addr_q),
        .rdata    (mem_rdata),
        .fail     (fail),
        .fail_data(fail_data),
        .fail_addr(fail_addr)
    );

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: timed fault-injecting memory, untimed March C-
// reference model feeding a scoreboard, monitor checking at falling edges.
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy, done, fail;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic       mem_write_read;
    logic [3:0] mem_address;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    typedef struct {
        logic       f;
        logic [3:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] wr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_done = 0;
    int          run_cyc = 0;
    bit          active = 0;

    int f_kind = 0, f_addr = 0, f_bit = 0;
    logic f_val = 1'b0;

    logic [7:0] tmem[16];
    logic [7:0] ref_mem[16];
    logic [7:0] wdata_q, rd1, rd2;

    always #5 clk = ~clk;

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CAPACITY(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .fail_addr     (fail_addr),
        .fail_data     (fail_data),
        .mem_write_read(mem_write_read),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Fault 1: stuck bit at one address. Fault 2: address 7 bit 1 reads 0
    // while neighbours {6,8,5,9} bit 0 show 1010.
    function automatic logic [7:0] fault_apply(input logic [7:0] v, input int a, input logic [3:0] nb);
        logic [7:0] r;
        r = v;
        if (f_kind == 1 && a == f_addr) r[f_bit] = f_val;
        if (f_kind == 2 && a == 7 && nb == 4'b1010) r[1] = 1'b0;
        return r;
    endfunction

    // Test memory: wdata registered one cycle, reads return two cycles later.
    always @(posedge clk) begin
        wdata_q <= mem_wdata;
        if (mem_write_read) tmem[mem_address] <= wdata_q;
        rd1 <= fault_apply(tmem[mem_address], int'(mem_address),
                           {tmem[6][0], tmem[8][0], tmem[5][0], tmem[9][0]});
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    // Untimed March C-: queues the expected write stream and final result.
    task automatic ref_model();
        exp_t e;
        int a;
        logic [7:0] v, rexp, wv;
        e.f = 1'b0; e.a = '0; e.d = '0;
        for (int el = 0; el < 6; el++) begin
            rexp = (el == 2 || el == 4) ? 8'hFF : 8'h00;
            wv   = (el == 1 || el == 3) ? 8'hFF : 8'h00;
            for (int k = 0; k < 16; k++) begin
                a = (el == 3 || el == 4) ? 15 - k : k;
                if (el != 0) begin
                    v = fault_apply(ref_mem[a], a,
                                    {ref_mem[6][0], ref_mem[8][0], ref_mem[5][0], ref_mem[9][0]});
                    if (!e.f && v != rexp) begin
                        e.f = 1'b1; e.a = 4'(a); e.d = v;
                    end
                end
                if (el != 5) begin
                    ref_mem[a] = wv;
                    wr_q.push_back({4'(a), wv});
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: write stream, busy window, done timing and final result.
    always @(negedge clk) begin
        logic [11:0] w;
        exp_t e;
        if (!rst_n) begin
            active = 0;
        end else begin
            if (mem_write_read) begin
                if (wr_q.size() == 0) chk("unexpected_write", {mem_address, wdata_q}, 32'hFFFF);
                else begin
                    w = wr_q.pop_front();
                    chk("write_addr_data", {20'd0, mem_address, wdata_q}, {20'd0, w});
                end
            end
            if (active) begin
                run_cyc++;
                if (run_cyc < 169) chk("busy_window", busy, 1);
                if (run_cyc == 1) chk("fail_clear_setup", fail, 0);
            end
            if (done) begin
                n_done++;
                chk("done_while_running", active, 1);
                chk("done_cycle", run_cyc, 169);
                chk("busy_at_done", busy, 0);
                if (exp_q.size() == 0) chk("done_without_test", 0, 1);
                else begin
                    e = exp_q.pop_front();
                    chk("fail", fail, e.f);
                    chk("fail_addr", fail_addr, e.a);
                    chk("fail_data", fail_data, e.d);
                    chk("writes_remaining", wr_q.size(), 0);
                end
                active = 0;
            end
            if (start && !busy && !done) begin
                active  = 1;
                run_cyc = 0;
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_fail"}, fail, 0);
        chk({tag, "_fail_addr"}, fail_addr, 0);
        chk({tag, "_fail_data"}, fail_data, 0);
        chk({tag, "_wr"}, mem_write_read, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic set_fault(input int kind, input int a, input int b, input logic v);
        f_kind = kind; f_addr = a; f_bit = b; f_val = v;
    endtask

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic run_test(input bit repulse);
        int nd0, c;
        ref_model();
        nd0 = n_done;
        pulse_start();
        c = 1;
        while (c < 400 && n_done == nd0) begin
            @(posedge clk); #2;
            c++;
            start = repulse && (c == 10 || c == 100);
        end
        start = 1'b0;
        if (n_done == nd0) chk("done_timeout", 0, 1);
        repeat (30) @(posedge clk);
        chk("single_done", n_done - nd0, 1);
    endtask

    task automatic abort_test();
        int nd0;
        set_fault(1, 2, 0, 1'b1);
        ref_model();
        nd0 = n_done;
        pulse_start();
        for (int c = 1; c < 50; c++) begin
            @(posedge clk); #2;
        end
        chk("fail_before_abort", fail, 1);
        #1 rst_n = 1'b0;
        #1 chk_zero("abort");
        exp_q.delete();
        wr_q.delete();
        set_fault(0, 0, 0, 1'b0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (200) @(posedge clk);
        chk("no_done_after_abort", n_done - nd0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("in_reset");
        #2 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2 chk_zero("after_reset");

        set_fault(0, 0, 0, 1'b0);  run_test(0);
        set_fault(1, 5, 1, 1'b0);  run_test(0);
        set_fault(2, 0, 0, 1'b0);  run_test(0);
        abort_test();
        run_test(0);
        set_fault(0, 0, 0, 1'b0);  run_test(1);
        set_fault(1, 11, 6, 1'b1); run_test(0);
        set_fault(0, 0, 0, 1'b0);  run_test(0);
        for (int i = 0; i < 6; i++) begin
            set_fault(int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            run_test(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
